// File: rtl/ex_mem_register.sv
// EX/MEM pipeline register.
// Captures the execute-stage result and control bundle and presents it to the
// memory stage. A stall from MEM holds the contents. A flush turns the entry
// into a bubble by clearing the valid bit and every control bit, while the
// data fields keep their values. The block also drives the EX->EX forwarding
// bypass and load-use hazard detection, and counts the cycles MEM spends
// stalled on a valid instruction.
module ex_mem_register #(
  parameter int PERF_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall,
  input  logic              flush,
  input  logic              ex_valid,
  input  logic [31:0]       ex_alu_result,
  input  logic [31:0]       ex_write_data,
  input  logic [31:0]       ex_pc,
  input  logic [4:0]        ex_rd,
  input  logic [4:0]        ex_rs1,
  input  logic [4:0]        ex_rs2,
  input  logic              ex_is_load,
  input  logic              ex_is_store,
  input  logic              ex_is_write,
  input  logic              ex_load_unsigned,
  input  logic              ex_mov_rm,
  input  logic              ex_tlbwrite,
  input  logic              ex_iret,
  input  logic [1:0]        ex_mem_size,
  input  logic [31:0]       ex_rm_value,
  output logic              mem_valid,
  output logic [31:0]       mem_alu_result,
  output logic [31:0]       mem_write_data,
  output logic [31:0]       mem_pc,
  output logic [4:0]        mem_rd,
  output logic              mem_is_load,
  output logic              mem_is_store,
  output logic              mem_is_write,
  output logic              mem_load_unsigned,
  output logic              mem_mov_rm,
  output logic              mem_tlbwrite,
  output logic              mem_iret,
  output logic [1:0]        mem_mem_size,
  output logic [31:0]       mem_rm_value,
  output logic              fwd_en,
  output logic [4:0]        fwd_rd,
  output logic [31:0]       fwd_data,
  output logic              load_use_hazard,
  output logic [PERF_W-1:0] stall_count
);

  localparam logic [PERF_W-1:0] CNT_MAX = {PERF_W{1'b1}};
  localparam logic [PERF_W-1:0] CNT_ONE = {{(PERF_W-1){1'b0}}, 1'b1};

  logic rd_nonzero;

  // Valid bit and control bits: cleared by flush, held by stall. Control is
  // qualified with ex_valid so a bubble never carries a live control bit.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_valid         <= 1'b0;
      mem_is_load       <= 1'b0;
      mem_is_store      <= 1'b0;
      mem_is_write      <= 1'b0;
      mem_load_unsigned <= 1'b0;
      mem_mov_rm        <= 1'b0;
      mem_tlbwrite      <= 1'b0;
      mem_iret          <= 1'b0;
    end else if (flush) begin
      mem_valid         <= 1'b0;
      mem_is_load       <= 1'b0;
      mem_is_store      <= 1'b0;
      mem_is_write      <= 1'b0;
      mem_load_unsigned <= 1'b0;
      mem_mov_rm        <= 1'b0;
      mem_tlbwrite      <= 1'b0;
      mem_iret          <= 1'b0;
    end else if (!stall) begin
      mem_valid         <= ex_valid;
      mem_is_load       <= ex_is_load       & ex_valid;
      mem_is_store      <= ex_is_store      & ex_valid;
      mem_is_write      <= ex_is_write      & ex_valid;
      mem_load_unsigned <= ex_load_unsigned & ex_valid;
      mem_mov_rm        <= ex_mov_rm        & ex_valid;
      mem_tlbwrite      <= ex_tlbwrite      & ex_valid;
      mem_iret          <= ex_iret          & ex_valid;
    end
  end

  // Data fields: loaded only on an unstalled, unflushed edge; a flush leaves them as-is.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_alu_result <= '0;
      mem_write_data <= '0;
      mem_pc         <= '0;
      mem_rd         <= '0;
      mem_mem_size   <= '0;
      mem_rm_value   <= '0;
    end else if (!flush && !stall) begin
      mem_alu_result <= ex_alu_result;
      mem_write_data <= ex_write_data;
      mem_pc         <= ex_pc;
      mem_rd         <= ex_rd;
      mem_mem_size   <= ex_mem_size;
      mem_rm_value   <= ex_rm_value;
    end
  end

  // Saturating count of edges where a valid MEM instruction is held by a stall.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_count <= '0;
    end else if (stall && mem_valid && !flush && (stall_count != CNT_MAX)) begin
      stall_count <= stall_count + CNT_ONE;
    end
  end

  // Bypass and hazard outputs are combinational from the MEM copy and EX sources.
  always_comb begin
    rd_nonzero      = (mem_rd != 5'd0);
    fwd_en          = mem_valid & mem_is_write & ~mem_is_load & ~mem_mov_rm & rd_nonzero;
    fwd_rd          = mem_rd;
    fwd_data        = mem_alu_result;
    load_use_hazard = mem_valid & mem_is_load & rd_nonzero &
                      ((mem_rd == ex_rs1) | (mem_rd == ex_rs2));
  end

endmodule

// File: tb/tb_ex_mem_register.sv
module tb_ex_mem_register;

  localparam int PERF_W = 4;
  localparam int CMAX   = (1 << PERF_W) - 1;
  localparam int VW     = 186;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic stall = 1'b0, flush = 1'b0, ex_valid = 1'b0;
  logic [31:0] ex_alu_result = '0, ex_write_data = '0, ex_pc = '0, ex_rm_value = '0;
  logic [4:0]  ex_rd = '0, ex_rs1 = '0, ex_rs2 = '0;
  logic ex_is_load = 1'b0, ex_is_store = 1'b0, ex_is_write = 1'b0, ex_load_unsigned = 1'b0;
  logic ex_mov_rm = 1'b0, ex_tlbwrite = 1'b0, ex_iret = 1'b0;
  logic [1:0] ex_mem_size = '0;

  logic mem_valid, mem_is_load, mem_is_store, mem_is_write, mem_load_unsigned;
  logic mem_mov_rm, mem_tlbwrite, mem_iret, fwd_en, load_use_hazard;
  logic [31:0] mem_alu_result, mem_write_data, mem_pc, mem_rm_value, fwd_data;
  logic [4:0]  mem_rd, fwd_rd;
  logic [1:0]  mem_mem_size;
  logic [PERF_W-1:0] stall_count;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference view of what MEM should hold: a record updated by the edge rules.
  typedef struct {
    logic        valid;
    logic [31:0] alu, wdata, pc, rmv;
    logic [4:0]  rd;
    logic [1:0]  size;
    logic        ld, st, wr, lu, mr, tw, ir;
    int          cnt;
  } mem_t;
  mem_t m;

  ex_mem_register #(.PERF_W(PERF_W)) dut (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush), .ex_valid(ex_valid),
    .ex_alu_result(ex_alu_result), .ex_write_data(ex_write_data), .ex_pc(ex_pc),
    .ex_rd(ex_rd), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2),
    .ex_is_load(ex_is_load), .ex_is_store(ex_is_store), .ex_is_write(ex_is_write),
    .ex_load_unsigned(ex_load_unsigned), .ex_mov_rm(ex_mov_rm), .ex_tlbwrite(ex_tlbwrite),
    .ex_iret(ex_iret), .ex_mem_size(ex_mem_size), .ex_rm_value(ex_rm_value),
    .mem_valid(mem_valid), .mem_alu_result(mem_alu_result), .mem_write_data(mem_write_data),
    .mem_pc(mem_pc), .mem_rd(mem_rd), .mem_is_load(mem_is_load), .mem_is_store(mem_is_store),
    .mem_is_write(mem_is_write), .mem_load_unsigned(mem_load_unsigned),
    .mem_mov_rm(mem_mov_rm), .mem_tlbwrite(mem_tlbwrite), .mem_iret(mem_iret),
    .mem_mem_size(mem_mem_size), .mem_rm_value(mem_rm_value),
    .fwd_en(fwd_en), .fwd_rd(fwd_rd), .fwd_data(fwd_data),
    .load_use_hazard(load_use_hazard), .stall_count(stall_count)
  );

  always #5 clk = ~clk;

  function automatic void model_reset();
    m = '{default: 0};
  endfunction

  function automatic void model_edge();
    if (flush) begin
      m.valid = 0; m.ld = 0; m.st = 0; m.wr = 0; m.lu = 0; m.mr = 0; m.tw = 0; m.ir = 0;
    end else if (stall) begin
      if (m.valid && m.cnt < CMAX) m.cnt = m.cnt + 1;
    end else begin
      m.valid = ex_valid;
      m.alu = ex_alu_result; m.wdata = ex_write_data; m.pc = ex_pc; m.rmv = ex_rm_value;
      m.rd = ex_rd; m.size = ex_mem_size;
      m.ld = ex_is_load && ex_valid;   m.st = ex_is_store && ex_valid;
      m.wr = ex_is_write && ex_valid;  m.lu = ex_load_unsigned && ex_valid;
      m.mr = ex_mov_rm && ex_valid;    m.tw = ex_tlbwrite && ex_valid;
      m.ir = ex_iret && ex_valid;
    end
  endfunction

  function automatic logic [VW-1:0] exp_vec();
    logic fe, lh;
    fe = m.valid && m.wr && !m.ld && !m.mr && (m.rd != 0);
    lh = m.valid && m.ld && (m.rd != 0) && ((m.rd == ex_rs1) || (m.rd == ex_rs2));
    return {m.valid, m.alu, m.wdata, m.pc, m.rd, m.ld, m.st, m.wr, m.lu, m.mr, m.tw, m.ir,
            m.size, m.rmv, fe, m.rd, m.alu, lh, PERF_W'(m.cnt)};
  endfunction

  function automatic logic [VW-1:0] dut_vec();
    return {mem_valid, mem_alu_result, mem_write_data, mem_pc, mem_rd, mem_is_load,
            mem_is_store, mem_is_write, mem_load_unsigned, mem_mov_rm, mem_tlbwrite,
            mem_iret, mem_mem_size, mem_rm_value, fwd_en, fwd_rd, fwd_data,
            load_use_hazard, stall_count};
  endfunction

  task automatic clear_ex();
    ex_valid = 0; ex_alu_result = 0; ex_write_data = 0; ex_pc = 0; ex_rm_value = 0;
    ex_rd = 0; ex_rs1 = 0; ex_rs2 = 0; ex_mem_size = 0;
    ex_is_load = 0; ex_is_store = 0; ex_is_write = 0; ex_load_unsigned = 0;
    ex_mov_rm = 0; ex_tlbwrite = 0; ex_iret = 0;
  endtask

  task automatic random_ex();
    ex_valid = ($urandom_range(0, 3) != 0);
    ex_alu_result = $urandom; ex_write_data = $urandom; ex_pc = $urandom;
    ex_rm_value = $urandom;
    ex_rd = 5'($urandom_range(0, 7)); ex_rs1 = 5'($urandom_range(0, 7));
    ex_rs2 = 5'($urandom_range(0, 7));
    ex_mem_size = ($urandom_range(0, 1) != 0) ? 2'b10 : 2'b00;
    ex_is_load = 1'($urandom); ex_is_store = 1'($urandom); ex_is_write = 1'($urandom);
    ex_load_unsigned = 1'($urandom); ex_mov_rm = 1'($urandom);
    ex_tlbwrite = 1'($urandom); ex_iret = 1'($urandom);
  endtask

  // One rising edge; the model advances on it and the caller resumes at the falling edge.
  task automatic cycle();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    model_reset();
    #2 reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    stall = 0; flush = 0; clear_ex();
    ex_valid = 1; ex_is_write = 1; ex_rd = 5'd3; ex_alu_result = 32'hCAFE_0001;
    cycle();
    stall = 1;
    cycle(); cycle();
    n_checks++;
    if (dut_vec() !== exp_vec()) begin
      n_fail++; $display("FAIL pre_reset_state got=%h exp=%h", dut_vec(), exp_vec());
    end
    #2 reset = 1'b1;
    model_reset();
    #1;
    n_checks++;
    if ({mem_valid, fwd_en, stall_count} !== {1'b0, 1'b0, {PERF_W{1'b0}}}) begin
      n_fail++; $display("FAIL async_reset got valid=%b fwd=%b cnt=%0d exp 0/0/0",
                         mem_valid, fwd_en, stall_count);
    end
    n_checks++;
    if (dut_vec() !== exp_vec()) begin
      n_fail++; $display("FAIL async_reset_all got=%h exp=%h", dut_vec(), exp_vec());
    end
    @(negedge clk);
    reset = 1'b0; stall = 0;
    cycle();
    n_checks++;
    if (mem_valid !== 1'b1 || mem_alu_result !== 32'hCAFE_0001) begin
      n_fail++; $display("FAIL first_load_after_reset got valid=%b alu=%h exp 1/cafe0001",
                         mem_valid, mem_alu_result);
    end
  endtask

  task automatic test_load_forward();
    stall = 0; flush = 0; clear_ex();
    ex_valid = 1; ex_is_write = 1; ex_rd = 5'd5; ex_alu_result = 32'h1234;
    cycle();
    n_checks++;
    if ({mem_valid, fwd_en, fwd_rd, fwd_data} !== {1'b1, 1'b1, 5'd5, 32'h1234}) begin
      n_fail++; $display("FAIL forward got valid=%b en=%b rd=%0d data=%h exp 1/1/5/1234",
                         mem_valid, fwd_en, fwd_rd, fwd_data);
    end
    ex_rd = 5'd0;
    cycle();
    n_checks++;
    if (fwd_en !== 1'b0) begin
      n_fail++; $display("FAIL forward_rd0 got en=%b exp 0", fwd_en);
    end
  endtask

  task automatic test_stall_hold();
    logic [31:0] a_alu, b_alu;
    do_reset();
    stall = 0; flush = 0;
    random_ex(); ex_valid = 1; a_alu = ex_alu_result;
    cycle();
    random_ex(); ex_valid = 1; b_alu = ~a_alu; ex_alu_result = b_alu;
    stall = 1;
    for (int i = 0; i < 3; i++) begin
      cycle();
      n_checks++;
      if (dut_vec() !== exp_vec() || mem_alu_result !== a_alu) begin
        n_fail++; $display("FAIL stall_hold[%0d] got=%h exp=%h", i, dut_vec(), exp_vec());
      end
    end
    n_checks++;
    if (stall_count !== PERF_W'(3)) begin
      n_fail++; $display("FAIL stall_count3 got=%0d exp=3", stall_count);
    end
    stall = 0;
    cycle();
    n_checks++;
    if (mem_alu_result !== b_alu || mem_valid !== 1'b1) begin
      n_fail++; $display("FAIL stall_release got alu=%h exp=%h", mem_alu_result, b_alu);
    end
  endtask

  task automatic test_flush_stall();
    logic [PERF_W-1:0] cnt_before;
    stall = 0; flush = 0; clear_ex();
    ex_valid = 1; ex_is_store = 1; ex_alu_result = 32'hDEAD_0000; ex_write_data = 32'h55;
    cycle();
    cnt_before = stall_count;
    stall = 1; flush = 1;
    cycle();
    n_checks++;
    if ({mem_valid, mem_is_store, mem_alu_result, stall_count} !==
        {1'b0, 1'b0, 32'hDEAD_0000, cnt_before}) begin
      n_fail++; $display("FAIL flush_stall got valid=%b st=%b alu=%h cnt=%0d exp 0/0/dead0000/%0d",
                         mem_valid, mem_is_store, mem_alu_result, stall_count, cnt_before);
    end
    n_checks++;
    if (dut_vec() !== exp_vec()) begin
      n_fail++; $display("FAIL flush_stall_all got=%h exp=%h", dut_vec(), exp_vec());
    end
    stall = 0; flush = 0;
  endtask

  task automatic test_load_use();
    stall = 0; flush = 0; clear_ex();
    ex_valid = 1; ex_is_load = 1; ex_is_write = 1; ex_rd = 5'd7;
    cycle();
    clear_ex(); ex_rs1 = 5'd1; ex_rs2 = 5'd7;
    #1;
    n_checks++;
    if ({load_use_hazard, fwd_en} !== 2'b10) begin
      n_fail++; $display("FAIL load_use got haz=%b fwd=%b exp 1/0", load_use_hazard, fwd_en);
    end
    ex_rs2 = 5'd8;
    #1;
    n_checks++;
    if (load_use_hazard !== 1'b0) begin
      n_fail++; $display("FAIL load_use_clear got haz=%b exp 0", load_use_hazard);
    end
    ex_rs1 = 5'd7; stall = 1;
    #1;
    n_checks++;
    if (load_use_hazard !== 1'b1) begin
      n_fail++; $display("FAIL load_use_rs1_stalled got haz=%b exp 1", load_use_hazard);
    end
    stall = 0;
    @(negedge clk);
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 300; i++) begin
      random_ex();
      stall = ($urandom_range(0, 3) == 0);
      flush = ($urandom_range(0, 9) == 0);
      cycle();
      n_checks++;
      if (dut_vec() !== exp_vec()) begin
        n_fail++; $display("FAIL random[%0d] got=%h exp=%h", i, dut_vec(), exp_vec());
      end
    end
    stall = 0; flush = 0;
  endtask

  task automatic test_saturation();
    do_reset();
    stall = 0; flush = 0; clear_ex();
    ex_valid = 1; ex_is_write = 1; ex_rd = 5'd9;
    cycle();
    stall = 1;
    for (int i = 0; i < 20; i++) begin
      cycle();
      n_checks++;
      if (stall_count !== PERF_W'(m.cnt)) begin
        n_fail++; $display("FAIL sat_step[%0d] got=%0d exp=%0d", i, stall_count, m.cnt);
      end
    end
    n_checks++;
    if (stall_count !== PERF_W'(CMAX)) begin
      n_fail++; $display("FAIL saturate got=%0d exp=%0d", stall_count, CMAX);
    end
    stall = 0; clear_ex(); ex_is_store = 1;
    cycle();
    n_checks++;
    if ({mem_valid, mem_is_store, stall_count} !== {1'b0, 1'b0, PERF_W'(CMAX)}) begin
      n_fail++; $display("FAIL bubble got valid=%b st=%b cnt=%0d exp 0/0/%0d",
                         mem_valid, mem_is_store, stall_count, CMAX);
    end
  endtask

  initial begin
    model_reset();
    clear_ex();
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    test_reset();
    test_load_forward();
    test_stall_hold();
    test_flush_stall();
    test_load_use();
    test_random();
    test_saturation();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
